dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder on the far end of the load/store unit's memory port. It accepts one byte, halfword or word access per request into a 4 KiB byte-addressed array of 32-bit words. Misaligned accesses are split into two word accesses, including wrap from the top word to word 0. Load data is returned right-justified and zero-filled; the load/store unit applies sign or zero extension. Sits between the load/store unit and the data SRAM array in the core's memory stage.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; the byte address is 12 bits.
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  1  access request; accepted on a rising edge when req_i and ready_o are both 1.
- mem_wr_i  input  1  1 = store, 0 = load; sampled at accept.
- rwtype_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal; sampled at accept.
- data_addr_i  input  12  byte address; sampled at accept.
- data_i  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]); sampled at accept.
- ready_o  output  1  high only in IDLE.
- done_o  output  1  one-cycle completion pulse.
- data_o  output  32  load result, right-justified, upper bits zero; valid while done_o is high for a load.
- err_o  output  1  high with done_o when rwtype was 11.

## Operation
- Request register: holds address, type, write flag and store data, latched at accept.
  - Derived: word index w = addr[11:2], offset o = addr[1:0], size n = 1, 2 or 4 bytes.
- Split rule:
  - Access crosses a word boundary when o + n > 4: halfword at o = 3, or word at o ≠ 0.
  - Second word index = (w + 1) mod DEPTH_WORDS, so word 1023 wraps to word 0.
- Byte ordering is little-endian: byte k of the access maps to memory address (addr + k) mod 4096.
- Stores:
  - Per-word byte enables are derived from o and n; only enabled bytes change.
  - First word carries bytes 0..(3−o) of data_i; second word carries the remainder, in its lanes starting at lane 0.
- Loads:
  - Each word is read in its access state and captured.
  - Bytes are assembled in the RESP state into data_o[8n−1:0]; the remaining bits are 0.
- Illegal rwtype (11): no memory access. done_o = 1, err_o = 1, data_o unchanged.
- data_o updates only on load completions and holds between them.
- State machine:
  - IDLE: ready_o = 1. On accept → FIRST, or → RESP with err_o pending if rwtype = 11.
  - FIRST: access word w. → SECOND if split, else → RESP.
  - SECOND: access word w+1. → RESP.
  - RESP: done_o = 1, err_o valid, data_o valid for loads. → IDLE.
- req_i outside IDLE is ignored; the requester must hold it until accepted.
- Memory contents are not reset.

## Timing
- Reset values: ready_o = 1, done_o = 0, data_o = 0, err_o = 0; state = IDLE.
- Accept at edge E0.
  - Aligned access: FIRST in cycle 1, done_o high in cycle 2 (latency 2).
  - Split access: FIRST in cycle 1, SECOND in cycle 2, done_o in cycle 3 (latency 3).
  - Illegal type: done_o in cycle 1.
- Writes commit at the edge ending FIRST, and SECOND for the second half.
- A load issued the cycle after a store's done_o sees the stored data.
- Back-to-back throughput: one request every 3 cycles aligned, 4 split; ready_o returns high the cycle after done_o.
- Reset during FIRST or SECOND:
  - Aborts the access immediately; no done_o is issued.
  - A store's first half already committed stays; an uncommitted second half is dropped.

## Test plan
- Aligned word: sw 0xDEADBEEF at 0x010, then lw 0x010 → data_o = 0xDEADBEEF. done_o exactly 2 cycles after each accept; ready_o low for the 2 busy cycles.
- Byte merge: after the above, sb 0x1234_56A5 at 0x013, then lw 0x010 → 0xA5ADBEEF; lb 0x013 → 0x000000A5.
- Split halfword: sh 0x1234 at 0x013, then lh 0x013 → 0x00001234 with latency 3; lw 0x014 → low byte 0x12, other bytes unchanged.
- Wrap: sw 0x11223344 at 0xFFE → lh 0xFFE = 0x00003344, lh 0x000 = 0x00001122; lw 0xFFE = 0x11223344 (latency 3).
- Illegal/ignore: rwtype 11 store at 0x020 → done_o and err_o in cycle 1, memory at 0x020 unchanged; req_i pulsed while busy → no second done_o.
- Reset mid-split: sw 0xAABBCCDD at 0x0FE, assert rst during SECOND → no done_o, all outputs at reset values. lh 0x0FE = 0x0000CCDD; word 0x100 keeps its prior contents.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: byte/halfword/word data-memory responder with misaligned split and wrap.
module dmem_resp #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  rwtype_i,
    input  logic [11:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} state_t;
    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [1:0]  type_q, type_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d, r0_q, r0_d, data_q, data_d;
    logic        ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic [31:0] mem [DEPTH_WORDS];
    logic [9:0]  w, w2, widx;
    logic [1:0]  o;
    logic [3:0]  m, wbe;
    logic [7:0]  be;
    logic [63:0] sd;
    logic [31:0] rd0, rd1, ld, lmask, wd;
    logic        split, we;
    always_comb begin
        w     = addr_q[11:2];
        o     = addr_q[1:0];
        w2    = (w == 10'(DEPTH_WORDS - 1)) ? '0 : w + 10'd1;
        m     = type_q == 2'b00 ? 4'b0001 : type_q == 2'b01 ? 4'b0011 : 4'b1111;
        lmask = type_q == 2'b00 ? 32'h0000_00ff : type_q == 2'b01 ? 32'h0000_ffff : 32'hffff_ffff;
        be    = {4'b0, m} << o;
        split = |be[7:4];
        sd    = {32'b0, wdata_q} << {o, 3'b000};
        // first word is captured at the edge ending FIRST, second is read live in SECOND
        rd0   = state_q == FIRST ? mem[w] : r0_q;
        rd1   = mem[w2];
        ld    = 32'({rd1, rd0} >> {o, 3'b000});
        we    = wr_q && (state_q == FIRST || state_q == SECOND);
        widx  = state_q == SECOND ? w2 : w;
        wbe   = state_q == SECOND ? be[7:4] : be[3:0];
        wd    = state_q == SECOND ? sd[63:32] : sd[31:0];
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        r0_d    = rd0;
        if (state_q == IDLE && req_i) begin
            addr_d  = data_addr_i;
            type_d  = rwtype_i;
            wr_d    = mem_wr_i;
            wdata_d = data_i;
            state_d = rwtype_i == 2'b11 ? RESP : FIRST;
        end else if (state_q == FIRST) begin
            state_d = split ? SECOND : RESP;
        end else if (state_q == SECOND) begin
            state_d = RESP;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        ready_d = state_d == IDLE;
        done_d  = state_d == RESP;
        err_d   = state_d == RESP && state_q == IDLE;
        data_d  = (state_d == RESP && state_q != IDLE && !wr_q) ? (ld & lmask) : data_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            r0_q    <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            r0_q    <= r0_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    // array is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && wbe[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
    end
    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign data_o  = data_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed-vector bench for dmem_resp with hand-computed expectations.
module tb_dmem_resp;
    logic        clk = 0, rst = 1, req_i = 0, mem_wr_i = 0;
    logic [1:0]  rwtype_i = 0;
    logic [11:0] data_addr_i = 0;
    logic [31:0] data_i = 0;
    logic        ready_o, done_o, err_o;
    logic [31:0] data_o;
    int          checks = 0, errors = 0;
    logic [31:0] rd;
    logic        er;

    dmem_resp #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .mem_wr_i(mem_wr_i), .rwtype_i(rwtype_i),
        .data_addr_i(data_addr_i), .data_i(data_i), .ready_o(ready_o), .done_o(done_o),
        .data_o(data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [1:0] t, input logic [11:0] a,
                        input logic [31:0] d, input int lat, output logic [31:0] dout, output logic e);
        int c;
        @(negedge clk);
        req_i = 1; mem_wr_i = wr; rwtype_i = t; data_addr_i = a; data_i = d;
        @(posedge clk); #1;
        req_i = 0; data_i = 32'h0; data_addr_i = 12'h0;
        c = 1;
        check({tag, " busy"}, 32'(ready_o), 32'd0);
        while (!done_o && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        check({tag, " lat"}, 32'(c), 32'(lat));
        dout = data_o;
        e = err_o;
        @(posedge clk); #1;
        check({tag, " idle"}, {30'b0, ready_o, done_o}, 32'h2);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst", {29'b0, ready_o, done_o, err_o}, 32'h4);
        check("rst data", data_o, 32'h0);
        @(negedge clk) rst = 0;

        xfer("sw010", 1, 2'b10, 12'h010, 32'hDEADBEEF, 2, rd, er);
        xfer("lw010", 0, 2'b10, 12'h010, 32'h0, 2, rd, er);
        check("lw010 data", rd, 32'hDEADBEEF);
        check("lw010 err", 32'(er), 32'd0);

        xfer("sb013", 1, 2'b00, 12'h013, 32'h123456A5, 2, rd, er);
        xfer("lw010b", 0, 2'b10, 12'h010, 32'h0, 2, rd, er);
        check("lw010b data", rd, 32'hA5ADBEEF);
        xfer("lb013", 0, 2'b00, 12'h013, 32'h0, 2, rd, er);
        check("lb013 data", rd, 32'h000000A5);

        xfer("sw014", 1, 2'b10, 12'h014, 32'h55667788, 2, rd, er);
        xfer("sh013", 1, 2'b01, 12'h013, 32'hFFFF1234, 3, rd, er);
        xfer("lh013", 0, 2'b01, 12'h013, 32'h0, 3, rd, er);
        check("lh013 data", rd, 32'h00001234);
        xfer("lw014", 0, 2'b10, 12'h014, 32'h0, 2, rd, er);
        check("lw014 data", rd, 32'h55667712);
        xfer("lw010c", 0, 2'b10, 12'h010, 32'h0, 2, rd, er);
        check("lw010c data", rd, 32'h34ADBEEF);

        xfer("swFFE", 1, 2'b10, 12'hFFE, 32'h11223344, 3, rd, er);
        xfer("lhFFE", 0, 2'b01, 12'hFFE, 32'h0, 2, rd, er);
        check("lhFFE data", rd, 32'h00003344);
        xfer("lh000", 0, 2'b01, 12'h000, 32'h0, 2, rd, er);
        check("lh000 data", rd, 32'h00001122);
        xfer("lwFFE", 0, 2'b10, 12'hFFE, 32'h0, 3, rd, er);
        check("lwFFE data", rd, 32'h11223344);

        xfer("sw020", 1, 2'b10, 12'h020, 32'hCAFEF00D, 2, rd, er);
        xfer("ill020", 1, 2'b11, 12'h020, 32'h0BADBAD0, 1, rd, er);
        check("ill err", 32'(er), 32'd1);
        check("ill data hold", rd, 32'h11223344);
        xfer("lw020", 0, 2'b10, 12'h020, 32'h0, 2, rd, er);
        check("lw020 data", rd, 32'hCAFEF00D);
        check("lw020 err", 32'(er), 32'd0);

        @(negedge clk);
        req_i = 1; mem_wr_i = 0; rwtype_i = 2'b10; data_addr_i = 12'h020;
        @(posedge clk); #1;
        req_i = 0;
        n = done_o ? 1 : 0;
        req_i = 1; mem_wr_i = 1; data_addr_i = 12'h020; data_i = 32'h0;
        @(posedge clk); #1;
        req_i = 0;
        for (int i = 0; i < 7; i++) begin
            n += done_o ? 1 : 0;
            @(posedge clk); #1;
        end
        check("busy ignore dones", 32'(n), 32'd1);
        xfer("lw020b", 0, 2'b10, 12'h020, 32'h0, 2, rd, er);
        check("lw020b data", rd, 32'hCAFEF00D);

        xfer("sw100", 1, 2'b10, 12'h100, 32'h99887766, 2, rd, er);
        @(negedge clk);
        req_i = 1; mem_wr_i = 1; rwtype_i = 2'b10; data_addr_i = 12'h0FE; data_i = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_i = 0;
        n = done_o ? 1 : 0;
        @(posedge clk); #1;
        n += done_o ? 1 : 0;
        rst = 1;
        #1;
        check("midrst outs", {29'b0, ready_o, done_o, err_o}, 32'h4);
        check("midrst data", data_o, 32'h0);
        @(posedge clk); #1;
        n += done_o ? 1 : 0;
        @(negedge clk) rst = 0;
        repeat (3) begin
            @(posedge clk); #1;
            n += done_o ? 1 : 0;
        end
        check("midrst no done", 32'(n), 32'd0);
        xfer("lh0FE", 0, 2'b01, 12'h0FE, 32'h0, 2, rd, er);
        check("lh0FE data", rd, 32'h0000CCDD);
        xfer("lw100", 0, 2'b10, 12'h100, 32'h0, 2, rd, er);
        check("lw100 data", rd, 32'h99887766);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
